// File: rtl/vid_pkg.sv
// Shared types and constants for the pixel pattern generator.
package vid_pkg;
  typedef logic [14:0] rgb555_t;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    PIX  = 2'd2
  } state_e;

  localparam rgb555_t C_WHITE = 15'h7FFF;
  localparam rgb555_t C_BLACK = 15'h0000;

  // Bar b: R=!b[1], G=!b[2], B=!b[0] gives white..black in broadcast order.
  function automatic rgb555_t bar_rgb(input logic [2:0] b);
    return {{5{~b[1]}}, {5{~b[2]}}, {5{~b[0]}}};
  endfunction
endpackage

// File: rtl/pix_pattern_color.sv
// Combinational pattern lookup: position, bar index and frame count to RGB555.
module pix_pattern_color
  import vid_pkg::*;
#(
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  mode_e            mode_i,
  input  logic [XW-1:0]    x_i,
  input  logic [YW-1:0]    y_i,
  input  logic [2:0]       bar_i,
  input  logic [7:0]       cnt_i,
  input  rgb555_t          solid_i,
  output rgb555_t          rgb_o
);
  logic [8:0] x9;
  logic [7:0] y8;
  logic [8:0] sum;

  // Patterns are defined on a 9-bit x / 8-bit y regardless of frame size.
  assign x9  = 9'(x_i);
  assign y8  = 8'(y_i);
  assign sum = x9 + {1'b0, cnt_i};

  always_comb begin
    rgb_o = C_BLACK;
    unique case (mode_i)
      MODE_SOLID: rgb_o = solid_i;
      MODE_BARS:  rgb_o = bar_rgb(bar_i);
      MODE_CHECK: rgb_o = (sum[4] ^ y8[4]) ? C_WHITE : C_BLACK;
      MODE_GRAD:  rgb_o = {x9[8:4], y8[7:3], cnt_i[4:0]};
      default:    rgb_o = C_BLACK;
    endcase
  end
endmodule

// File: rtl/pix_pattern_gen.sv
// Test-pattern pixel source: marker word then pW x pH raster pixels per frame,
// paced by the converter's write/full handshake.
module pix_pattern_gen
  import vid_pkg::*;
#(
  parameter int pW = 320,
  parameter int pH = 240
) (
  input  logic        iPIX_CLK,
  input  logic        iRESET,
  input  logic        iENABLE,
  input  logic [1:0]  iMODE,
  input  logic [14:0] iSOLID_RGB,
  input  logic        iPIX_FULL,
  output logic        oPIX_START,
  output logic [14:0] oPIX_RGB,
  output logic        oPIX_WRITE,
  output logic        oFRAME_DONE,
  output logic [7:0]  oFRAME_CNT
);
  localparam int XW  = (pW > 1) ? $clog2(pW) : 1;
  localparam int YW  = (pH > 1) ? $clog2(pH) : 1;
  localparam int BW  = pW / 8;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [XW-1:0]  X_LAST  = XW'(pW - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(pH - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BW - 1);

  state_e         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [2:0]     bar_q, bar_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  mode_e          mode_q, mode_d;
  rgb555_t        solid_q, solid_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           start_q, start_d;
  rgb555_t        rgb_q, rgb_d;
  rgb555_t        pix_rgb;
  logic           wr, ld;

  assign wr = (state_q != IDLE) && !iPIX_FULL;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    bar_d   = bar_q;
    bcnt_d  = bcnt_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (iENABLE) state_d = MARK;
      MARK: if (wr) begin
        mode_d  = mode_e'(iMODE);
        solid_d = iSOLID_RGB;
        x_d     = '0;
        y_d     = '0;
        bar_d   = '0;
        bcnt_d  = '0;
        state_d = PIX;
      end
      PIX: if (wr) begin
        if (x_q == X_LAST) begin
          x_d    = '0;
          bar_d  = '0;
          bcnt_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = iENABLE ? MARK : IDLE;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
          // Bar index advances every pW/8 pixels without a divider.
          if (bcnt_q == BC_LAST) begin
            bcnt_d = '0;
            bar_d  = bar_q + 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  pix_pattern_color #(.XW(XW), .YW(YW)) u_color (
    .mode_i  (mode_d),
    .x_i     (x_d),
    .y_i     (y_d),
    .bar_i   (bar_d),
    .cnt_i   (cnt_d),
    .solid_i (solid_d),
    .rgb_o   (pix_rgb)
  );

  // Output word is preloaded for the next position so writes can stream back to back.
  always_comb begin
    ld      = (state_q == IDLE) || wr;
    start_d = (state_d == MARK);
    rgb_d   = (state_d == PIX) ? pix_rgb : C_BLACK;
  end

  always_ff @(posedge iPIX_CLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bar_q   <= '0;
      bcnt_q  <= '0;
      mode_q  <= MODE_SOLID;
      solid_q <= C_BLACK;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      rgb_q   <= C_BLACK;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bar_q   <= bar_d;
      bcnt_q  <= bcnt_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (ld) begin
        start_q <= start_d;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign oPIX_START  = start_q;
  assign oPIX_RGB    = rgb_q;
  assign oPIX_WRITE  = wr;
  assign oFRAME_DONE = done_q;
  assign oFRAME_CNT  = cnt_q;
endmodule

// File: tb/tb_pix_pattern_gen.sv
// Bench for pix_pattern_gen on a reduced 64x32 frame.
module tb_pix_pattern_gen;
  localparam int PW = 64, PH = 32, NPIX = PW * PH;

  logic clk = 1'b0;
  logic rst, en, full;
  logic [1:0] mode;
  logic [14:0] solid;
  logic start, wr, done;
  logic [14:0] rgb;
  logic [7:0] fcnt;

  pix_pattern_gen #(.pW(PW), .pH(PH)) dut (
    .iPIX_CLK(clk), .iRESET(rst), .iENABLE(en), .iMODE(mode), .iSOLID_RGB(solid),
    .iPIX_FULL(full), .oPIX_START(start), .oPIX_RGB(rgb), .oPIX_WRITE(wr),
    .oFRAME_DONE(done), .oFRAME_CNT(fcnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int m_pix = 0, m_cnt = 0, wr_total = 0, frame_words = 0, done_words = 0, done_seen = 0;
  bit m_mark = 1, m_active = 0, done_exp = 0, after_rst = 0, bp_en = 0;
  int f_mode = 0;
  logic [14:0] f_solid = '0;
  logic [14:0] cap [2][NPIX];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] exp_rgb(input int md, input logic [14:0] sc, input int cnt,
                                          input int x, input int y);
    int b, c;
    case (md)
      0: return sc;
      1: begin
        b = x / (PW / 8);
        case (b)
          0: return 15'h7FFF;
          1: return 15'h7FE0;
          2: return 15'h03FF;
          3: return 15'h03E0;
          4: return 15'h7C1F;
          5: return 15'h7C00;
          6: return 15'h001F;
          default: return 15'h0000;
        endcase
      end
      2: begin
        c = ((((x + cnt) % 512) / 16) % 2) ^ ((y / 16) % 2);
        return (c != 0) ? 15'h7FFF : 15'h0000;
      end
      default: return 15'(((x % 512) / 16) * 1024 + ((y / 8) % 32) * 32 + (cnt % 32));
    endcase
  endfunction

  // Reference stream: marker, then NPIX pixels in raster order, per frame.
  initial begin
    bit nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_mark = 1; m_pix = 0; m_cnt = 0; m_active = 0; done_exp = 0; after_rst = 1;
      end else begin
        if (after_rst) begin
          chk("rst_start", 32'(start), 0);
          chk("rst_rgb", 32'(rgb), 0);
          after_rst = 0;
        end
        chk("done", 32'(done), 32'(done_exp));
        chk("frame_cnt", 32'(fcnt), 32'(m_cnt % 256));
        chk("write", 32'(wr), 32'(m_active && !full));
        if (done) begin
          done_words = frame_words;
          done_seen++;
        end
        done_exp = 0;
        nxt = m_active ? 1'b1 : en;
        if (wr) begin
          wr_total++;
          if (start) frame_words = 0;
          else frame_words++;
          if (m_mark) begin
            chk("marker_start", 32'(start), 1);
            chk("marker_rgb", 32'(rgb), 0);
            f_mode = int'(mode); f_solid = solid; m_mark = 0; m_pix = 0;
          end else begin
            chk("pix_start", 32'(start), 0);
            chk("pix_rgb", 32'(rgb), 32'(exp_rgb(f_mode, f_solid, m_cnt, m_pix % PW, m_pix / PW)));
            cap[m_cnt % 2][m_pix] = rgb;
            m_pix++;
            if (m_pix == NPIX) begin
              done_exp = 1; m_cnt++; m_mark = 1; nxt = en;
            end
          end
        end
        m_active = nxt;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      full = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_pix(input int n);
    int t = 0;
    while (m_pix != n && t < 20000) begin tick(); t++; end
    if (m_pix != n) begin
      n_chk++; n_err++;
      $display("FAIL wait_pix: got pixel %0d expected %0d", m_pix, n);
    end
  endtask

  task automatic wait_done();
    int d0 = done_seen, t = 0;
    while (done_seen == d0 && t < 20000) begin tick(); t++; end
    if (done_seen == d0) begin
      n_chk++; n_err++;
      $display("FAIL wait_done: got no frame_done expected a pulse");
    end
  endtask

  initial begin
    int w0, d0;
    rst = 1; en = 0; mode = 0; solid = 0; full = 0;
    // Reset and idle
    repeat (3) tick();
    rst = 0;
    repeat (100) tick();
    chk("idle_writes", 32'(wr_total), 0);
    chk("idle_start", 32'(start), 0);
    chk("idle_rgb", 32'(rgb), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_cnt", 32'(fcnt), 0);

    // Solid frame
    mode = 2'd0; solid = 15'h1234; en = 1;
    d0 = done_seen;
    wait_pix(5); en = 0;
    wait_done();
    chk("solid_cnt", 32'(fcnt), 1);
    chk("solid_words", 32'(done_words), NPIX);
    chk("solid_first", 32'(cap[0][0]), 32'h1234);
    chk("solid_last", 32'(cap[0][NPIX-1]), 32'h1234);
    w0 = wr_total;
    repeat (20) tick();
    chk("solid_idle_writes", 32'(wr_total - w0), 0);
    chk("solid_done_pulses", 32'(done_seen - d0), 1);

    // Gradient under random backpressure
    mode = 2'd3; en = 1; bp_en = 1;
    wait_pix(5); en = 0;
    wait_done();
    bp_en = 0;
    chk("bp_words", 32'(done_words), NPIX);
    chk("grad_63_31", 32'(cap[1][31*PW+63]), 32'h0C61);
    chk("grad_16_8", 32'(cap[1][8*PW+16]), 32'h0421);
    chk("bp_cnt", 32'(fcnt), 2);

    // Bars, enable dropped at pixel 1000
    mode = 2'd1; en = 1;
    wait_pix(1000); en = 0;
    wait_done();
    chk("bars_words", 32'(done_words), NPIX);
    chk("bars_x7", 32'(cap[0][7]), 32'h7FFF);
    chk("bars_x8", 32'(cap[0][8]), 32'h7FE0);
    chk("bars_x32", 32'(cap[0][32]), 32'h7C1F);
    chk("bars_x63", 32'(cap[0][63]), 32'h0000);
    chk("bars_l5_x8", 32'(cap[0][5*PW+8]), 32'h7FE0);
    chk("bars_l31_x63", 32'(cap[0][NPIX-1]), 32'h0000);
    w0 = wr_total;
    repeat (50) tick();
    chk("bars_idle_writes", 32'(wr_total - w0), 0);
    chk("bars_cnt", 32'(fcnt), 3);

    // Reset mid-frame, then two checker frames with a mid-frame mode change
    mode = 2'd0; solid = 15'h0F0F; en = 1;
    wait_pix(500);
    rst = 1; mode = 2'd2;
    tick();
    rst = 0;
    chk("mrst_start", 32'(start), 0);
    chk("mrst_rgb", 32'(rgb), 0);
    chk("mrst_write", 32'(wr), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_cnt", 32'(fcnt), 0);
    wait_pix(100);
    mode = 2'd0; solid = 15'h5555;
    wait_pix(1500);
    mode = 2'd2;
    wait_done();
    chk("chk0_words", 32'(done_words), NPIX);
    chk("chk0_16_0", 32'(cap[0][16]), 32'h7FFF);
    chk("chk0_0_0", 32'(cap[0][0]), 32'h0000);
    chk("chk0_31_0", 32'(cap[0][31]), 32'h7FFF);
    chk("chk0_0_20", 32'(cap[0][20*PW]), 32'h7FFF);
    chk("chk0_20_20", 32'(cap[0][20*PW+20]), 32'h0000);
    wait_pix(5); en = 0;
    wait_done();
    chk("chk1_15_0", 32'(cap[1][15]), 32'h7FFF);
    chk("chk1_0_0", 32'(cap[1][0]), 32'h0000);
    chk("chk1_31_0", 32'(cap[1][31]), 32'h0000);
    chk("chk1_16_0", 32'(cap[1][16]), 32'h7FFF);
    chk("chk1_cnt", 32'(fcnt), 2);
    w0 = wr_total;
    repeat (30) tick();
    chk("end_idle_writes", 32'(wr_total - w0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pix_pattern_gen.md
# pix_pattern_gen

Upstream pixel source for the 320x240 scanline converter. Emits one frame-start marker word, then the pW×pH pixels of the frame in raster order. Pixels are generated test patterns (solid, colour bars, scrolling checkerboard, gradient). Writes follow the converter's `iPIX_WRITE` / `oPIX_FULL` handshake, so the video path can be brought up without a camera or renderer.

## Interface
- `pW`, 320: active pixels per line; must be a multiple of 8.
- `pH`, 240: active lines per frame.
- `iPIX_CLK`  in  1: the single clock; same clock as the converter's write side.
- `iRESET`  in  1: reset, synchronous, active-high.
- `iENABLE`  in  1: level; 1 = stream frames continuously.
- `iMODE`  in  2: pattern select; latched once per frame.
- `iSOLID_RGB`  in  15: colour for mode 0; latched with `iMODE`.
- `iPIX_FULL`  in  1: converter buffer full; no write allowed while high.
- `oPIX_START`  out  1: 1 on the marker word only.
- `oPIX_RGB`  out  15: RGB555 {R[14:10], G[9:5], B[4:0]}.
- `oPIX_WRITE`  out  1: write strobe; one word transferred per cycle it is high.
- `oFRAME_DONE`  out  1: one-cycle pulse after the last pixel of a frame is written.
- `oFRAME_CNT`  out  8: completed-frame counter; wraps 255→0.

## Operation
- **FSM states:** IDLE, MARK, PIX.
  - IDLE: if `iENABLE`=1, go to MARK.
  - MARK: emit the marker word (`oPIX_START`=1, `oPIX_RGB`=0).
    - On its write: latch `iMODE` and `iSOLID_RGB` into `rMODE` and `rSOLID`; set x=0, y=0; go to PIX.
  - PIX: emit pixel (x,y).
    - On write: x+1. At x=pW-1: x=0, y+1.
    - On write of (pW-1, pH-1): pulse `oFRAME_DONE` next cycle and increment `oFRAME_CNT`. Go to MARK if `iENABLE`=1, else IDLE.
- `iENABLE` falling mid-frame does not truncate: the current frame always completes with pW×pH pixels.
- Frame length is exactly 1 + pW×pH writes (76801 at defaults).
- x is 9 bits and y is 8 bits at defaults; size them with `$clog2(pW)` and `$clog2(pH)`.
- **Patterns** (cnt = `oFRAME_CNT` value during the frame):
  - 0, solid: `rSOLID`.
  - 1, bars: 8 bars of pW/8 px; bar index b from a bar counter, with no divider.
    - Each channel is 5'h1F or 0: R=!b[1], G=!b[2], B=!b[0].
    - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - 2, checker: 16×16 cells, cell = (x+cnt)[4] ^ y[4], using a 9-bit sum; 1 → 15'h7FFF, 0 → 0. Scrolls 1 px per frame.
  - 3, gradient: R=x[8:4], G=y[7:3], B=cnt[4:0].

## Timing
- **Reset values:** `oPIX_START`=0, `oPIX_RGB`=0, `oPIX_WRITE`=0, `oFRAME_DONE`=0, `oFRAME_CNT`=0. State=IDLE, x=y=0, bar counter=0.
- **Write strobe:** `oPIX_WRITE` = (state≠IDLE) && !`iPIX_FULL`, combinational. There is no registered lookahead, so a write is never issued while full.
- **Data registers:** `oPIX_START` and `oPIX_RGB` are registered and stay stable while stalled.
  - On a write they load the word for the next position, computed from the next-cycle x, y and mode.
  - This sustains one word per cycle when `iPIX_FULL`=0.
- **Latency:**
  - IDLE→MARK: 1 cycle after `iENABLE` is sampled high. The marker is presented in the MARK cycle.
  - First pixel: presented in the cycle after the marker write.
- **Stalls:** when `iPIX_FULL` is high, all counters hold; when it drops, the transfer resumes with the same word.
- **Reset mid-frame:** the partial frame is abandoned and the next frame starts with a marker. The converter resynchronises on the marker.
- **Back-to-back frames:** the marker follows the last pixel with no gap cycle.

## Structure
- Shared package `vid_pkg`:
  - mode enum: MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD;
  - state enum;
  - RGB555 typedef;
  - constants C_WHITE = 15'h7FFF and C_BLACK = 15'h0000.
- Sub-module `pix_pattern_color`: combinational (mode, x, y, bar, cnt, solid) → RGB555. The FSM, counters and output registers stay in the top.

## Test plan
- **Reset/idle:** assert `iRESET` 3 cycles with `iENABLE`=0 → all outputs 0, no writes for 100 cycles.
- **Solid frame:** `iMODE`=0, `iSOLID_RGB`=15'h1234, `iENABLE`=1, `iPIX_FULL`=0 → first write {START=1, RGB=0}, then exactly 76800 writes of 15'h1234; `oFRAME_DONE` pulses once; `oFRAME_CNT`=1.
- **Backpressure:** toggle `iPIX_FULL` randomly (50%) → no write while full, no word lost or duplicated, and the captured frame is bit-identical to the unstalled reference.
- **Bars:** mode 1 → x=39 is 15'h7FFF, x=40 is 15'h7FE0 (yellow), x=319 is 0, identical on every line.
- **Checker scroll and mode latch:** mode 2 → frame 0 pixel (16,0)=7FFF and (0,0)=0; frame 1 pixel (15,0)=7FFF. Changing `iMODE` mid-frame has no effect until the next marker.
- **Enable drop and reset:** drop `iENABLE` at pixel 1000 → the frame completes with 76800 pixels, then IDLE with no new marker. Assert `iRESET` at pixel 500 of a frame → outputs are reset values next cycle, and the next frame starts with a marker.
